// File: rtl/imm_gen_pipe.sv
// RV immediate generator with a DEPTH-entry output FIFO and a saturating illegal-opcode counter.
// Define IMMGEN_CSR_EN to decode SYSTEM/CSR instructions; otherwise SYSTEM is illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iInstrucao,
  output logic             oValid,
  input  logic             iReady,
  output logic [XLEN-1:0]  oImm,
  output logic [2:0]       oFmt,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oIllegalCnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMMGEN_CSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  logic [31:0]      ins;
  logic [2:0]       f3;
  logic [31:0]      dec_v32;
  logic [2:0]       dec_fmt;
  logic             dec_ill;
  logic [XLEN-1:0]  dec_imm;

  ent_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] ill_cnt_q;
  logic             acc, con;

  assign ins = iInstrucao;
  assign f3  = ins[14:12];

  // Every format fits a 32-bit value whose sign bit is the XLEN extension bit,
  // so decode at 32 bits and widen afterwards.
  always_comb begin
    dec_v32 = '0;
    dec_fmt = 3'd7;
    dec_ill = 1'b1;
    case (ins[6:0])
      OP_LOAD, OP_JALR: begin
        dec_v32 = {{20{ins[31]}}, ins[31:20]};
        dec_fmt = 3'd1; dec_ill = 1'b0;
      end
      OP_OPIMM: begin
        if (f3 == 3'b001 || f3 == 3'b101)
          dec_v32 = {26'b0, (XLEN == 64) ? ins[25] : 1'b0, ins[24:20]};
        else
          dec_v32 = {{20{ins[31]}}, ins[31:20]};
        dec_fmt = 3'd1; dec_ill = 1'b0;
      end
      OP_STORE: begin
        dec_v32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        dec_fmt = 3'd2; dec_ill = 1'b0;
      end
      OP_BRANCH: begin
        dec_v32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        dec_fmt = 3'd3; dec_ill = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec_v32 = {ins[31:12], 12'b0};
        dec_fmt = 3'd4; dec_ill = 1'b0;
      end
      OP_JAL: begin
        dec_v32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        dec_fmt = 3'd5; dec_ill = 1'b0;
      end
      OP_OP: begin
        dec_fmt = 3'd0; dec_ill = 1'b0;
      end
`ifdef IMMGEN_CSR_EN
      OP_SYSTEM: begin
        if (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) begin
          dec_v32 = {27'b0, ins[19:15]};
          dec_fmt = 3'd6;
        end else begin
          dec_v32 = {{20{ins[31]}}, ins[31:20]};
          dec_fmt = 3'd1;
        end
        dec_ill = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign dec_imm = {{32{dec_v32[31]}}, dec_v32};
  end else begin : g_x32
    assign dec_imm = dec_v32;
  end

  assign oReady = (cnt_q != FULL);
  assign oValid = (cnt_q != '0);
  assign acc    = iValid && oReady;
  assign con    = oValid && iReady;

  assign oImm        = mem_q[rd_q].imm;
  assign oFmt        = mem_q[rd_q].fmt;
  assign oIllegal    = mem_q[rd_q].ill;
  assign oIllegalCnt = ill_cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({acc, con})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ill_cnt_q <= '0;
    end else begin
      if (acc) begin
        mem_q[wr_q] <= '{imm: dec_imm, fmt: dec_fmt, ill: dec_ill};
        wr_q        <= wr_q + 1'b1;
        if (dec_ill && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + 1'b1;
      end
      if (con) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized self-checking bench for imm_gen_pipe against a queue-based reference model.
module tb_imm_gen_pipe;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             iCLK = 1'b0;
  logic             iRST, iValid, iReady, oReady, oValid, oIllegal;
  logic [31:0]      iInstrucao;
  logic [XLEN-1:0]  oImm;
  logic [2:0]       oFmt;
  logic [CNT_W-1:0] oIllegalCnt;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } exp_t;

  exp_t mq[$];
  int   m_cnt  = 0;
  int   checks = 0;
  int   errors = 0;

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady),
    .iInstrucao(iInstrucao), .oValid(oValid), .iReady(iReady),
    .oImm(oImm), .oFmt(oFmt), .oIllegal(oIllegal), .oIllegalCnt(oIllegalCnt)
  );

  always #5 iCLK = ~iCLK;

  // Reference decode: immediate value built as a signed integer from field weights.
  task automatic ref_dec(input logic [31:0] ins, output logic [XLEN-1:0] imm,
                         output logic [2:0] fmt, output logic ill);
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0]; f3 = ins[14:12];
    v = 0; fmt = 3'd7; ill = 1'b1;
    if (op == 7'b0000011 || op == 7'b1100111 ||
        (op == 7'b0010011 && f3 != 3'b001 && f3 != 3'b101)) begin
      v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0); fmt = 1; ill = 0;
    end else if (op == 7'b0010011) begin
      v = (XLEN == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]); fmt = 1; ill = 0;
    end else if (op == 7'b0100011) begin
      v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0); fmt = 2; ill = 0;
    end else if (op == 7'b1100011) begin
      v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
          - (ins[31] ? 4096 : 0); fmt = 3; ill = 0;
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      v = longint'(ins[30:12]) * 4096 - (ins[31] ? (longint'(1) << 31) : 0); fmt = 4; ill = 0;
    end else if (op == 7'b1101111) begin
      v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
          - (ins[31] ? (longint'(1) << 20) : 0); fmt = 5; ill = 0;
    end else if (op == 7'b0110011) begin
      v = 0; fmt = 0; ill = 0;
    end
`ifdef IMMGEN_CSR_EN
    else if (op == 7'b1110011) begin
      ill = 0;
      if (f3 >= 3'b101) begin v = longint'(ins[19:15]); fmt = 6; end
      else begin v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0); fmt = 1; end
    end
`endif
    imm = v[XLEN-1:0];
  endtask

  // Drives one cycle and advances the model; no comparisons here.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy);
    bit acc, con;
    logic [XLEN-1:0] e_imm; logic [2:0] e_fmt; logic e_ill;
    iValid = v; iInstrucao = ins; iReady = rdy;
    acc = v && (mq.size() < DEPTH);
    con = rdy && (mq.size() > 0);
    @(posedge iCLK); #1;
    if (con) void'(mq.pop_front());
    if (acc) begin
      ref_dec(ins, e_imm, e_fmt, e_ill);
      mq.push_back('{imm: e_imm, fmt: e_fmt, ill: e_ill});
      if (e_ill && m_cnt < CNT_MAX) m_cnt++;
    end
    iValid = 1'b0; iReady = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH) step(1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'b0000011;  1: w[6:0] = 7'b0010011;  2: w[6:0] = 7'b0010111;
      3: w[6:0] = 7'b0100011;  4: w[6:0] = 7'b0110011;  5: w[6:0] = 7'b0110111;
      6: w[6:0] = 7'b1100011;  7: w[6:0] = 7'b1100111;  8: w[6:0] = 7'b1101111;
      9: w[6:0] = 7'b1110011;  default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    iRST = 1'b1; iValid = 1'b0; iReady = 1'b0; iInstrucao = '0;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    mq.delete(); m_cnt = 0;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", oValid); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", oReady); end
    checks++; if (oImm !== '0) begin errors++; $display("FAIL rst_imm got %h want 0", oImm); end
    checks++; if (oFmt !== 3'd0 || oIllegal !== 1'b0) begin errors++; $display("FAIL rst_fmt got %0d/%b want 0/0", oFmt, oIllegal); end
    checks++; if (oIllegalCnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", oIllegalCnt); end
  endtask

  task automatic test_addi();
    logic [XLEN-1:0] exp_imm;
    exp_imm = '1; exp_imm[1:0] = 2'b00;
    step(1'b1, 32'hFFC10113, 1'b1);
    checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", oValid); end
    checks++; if (oFmt !== 3'd1) begin errors++; $display("FAIL addi_fmt got %0d want 1", oFmt); end
    checks++; if (oImm !== exp_imm) begin errors++; $display("FAIL addi_imm got %h want %h", oImm, exp_imm); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_imm;
    exp_imm = '1; exp_imm[1:0] = 2'b00;
    step(1'b1, 32'hFE000EE3, 1'b1);
    checks++; if (oFmt !== 3'd3 || oImm !== exp_imm) begin errors++; $display("FAIL b2b_beq got %0d/%h want 3/%h", oFmt, oImm, exp_imm); end
    step(1'b1, 32'h0000006F, 1'b1);
    checks++; if (oValid !== 1'b1 || oFmt !== 3'd5 || oImm !== '0) begin errors++; $display("FAIL b2b_jal got %b/%0d/%h want 1/5/0", oValid, oFmt, oImm); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", oValid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic [XLEN-1:0] ei; logic [2:0] ef; logic el;
    w[0] = 32'h00500093; w[1] = 32'h00A00113; w[2] = 32'h00F00193;
    step(1'b1, w[0], 1'b0);
    step(1'b1, w[1], 1'b0);
    checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", oReady); end
    step(1'b1, w[2], 1'b0);
    checks++; if (oReady !== 1'b0 || mq.size() != DEPTH) begin errors++; $display("FAIL bp_held got %b want 0", oReady); end
    ref_dec(w[0], ei, ef, el);
    checks++; if (oImm !== ei) begin errors++; $display("FAIL bp_head0 got %h want %h", oImm, ei); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b want 1", oReady); end
    ref_dec(w[1], ei, ef, el);
    checks++; if (oValid !== 1'b1 || oImm !== ei) begin errors++; $display("FAIL bp_head1 got %h want %h", oImm, ei); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", oValid); end
    step(1'b1, w[2], 1'b1);
    ref_dec(w[2], ei, ef, el);
    checks++; if (oValid !== 1'b1 || oImm !== ei) begin errors++; $display("FAIL bp_head2 got %h want %h", oImm, ei); end
    drain();
  endtask

  task automatic test_shift_lui();
    step(1'b1, 32'h40515093, 1'b1);
    checks++; if (oFmt !== 3'd1 || oImm !== XLEN'(5)) begin errors++; $display("FAIL srai got %0d/%h want 1/5", oFmt, oImm); end
    step(1'b1, 32'h123450B7, 1'b1);
    checks++; if (oFmt !== 3'd4 || oImm !== XLEN'(32'h12345000)) begin errors++; $display("FAIL lui got %0d/%h want 4/12345000", oFmt, oImm); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_ins(), $urandom_range(0, 2) != 0);
      checks++; if (oValid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid @%0d got %b want %b", n, oValid, mq.size() != 0); end
      checks++; if (oReady !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready @%0d got %b want %b", n, oReady, mq.size() < DEPTH); end
      checks++; if (oIllegalCnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt @%0d got %0d want %0d", n, oIllegalCnt, m_cnt); end
      if (mq.size() != 0) begin
        checks++;
        if (oImm !== mq[0].imm || oFmt !== mq[0].fmt || oIllegal !== mq[0].ill) begin
          errors++;
          $display("FAIL rnd_head @%0d got %h/%0d/%b want %h/%0d/%b", n, oImm, oFmt, oIllegal, mq[0].imm, mq[0].fmt, mq[0].ill);
        end
      end
    end
    drain();
  endtask

  task automatic test_illegal_sat();
    for (int n = 0; n < 300; n++) begin
      step(1'b1, 32'h0, 1'b1);
      checks++;
      if (oIllegal !== 1'b1 || oFmt !== 3'd7 || oIllegalCnt !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL ill_entry @%0d got %b/%0d/%0d want 1/7/%0d", n, oIllegal, oFmt, oIllegalCnt, m_cnt);
      end
    end
    checks++; if (oIllegalCnt !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL ill_sat got %0d want %0d", oIllegalCnt, CNT_MAX); end
    drain();
  endtask

  task automatic test_mid_reset_csr();
    logic [2:0] ef; logic [XLEN-1:0] ei;
    repeat (DEPTH) step(1'b1, 32'h0, 1'b0);
    iRST = 1'b1; iValid = 1'b1; iInstrucao = 32'hFFC10113; iReady = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0; iValid = 1'b0; iReady = 1'b0;
    mq.delete(); m_cnt = 0;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", oValid); end
    checks++; if (oIllegalCnt !== '0) begin errors++; $display("FAIL mrst_cnt got %0d want 0", oIllegalCnt); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b want 1", oReady); end
`ifdef IMMGEN_CSR_EN
    ef = 3'd6; ei = XLEN'(3);
`else
    ef = 3'd7; ei = '0;
`endif
    step(1'b1, 32'h3401D073, 1'b1);
    checks++; if (oFmt !== ef || oImm !== ei) begin errors++; $display("FAIL csr got %0d/%h want %0d/%h", oFmt, oImm, ef, ei); end
    checks++; if (oIllegalCnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL csr_cnt got %0d want %0d", oIllegalCnt, m_cnt); end
    drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_shift_lui();
    test_random();
    test_illegal_sat();
    test_mid_reset_csr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
